// File: rtl/slr_cross_arbiter_pkg.sv
// Shared types and width helpers for the SLR crossing arbiter.
package slr_cross_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int unsigned id_w(input int unsigned num_req);
        return $clog2(num_req);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/slr_cross_arbiter_if.sv
// Requester-side handshake bundle plus the crossing-side beat and credit return.
interface slr_cross_arbiter_if
    import slr_cross_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
);
    localparam int unsigned ID_W = id_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          xmit_valid;
    logic                          xmit_last;
    logic [ID_W-1:0]               xmit_id;
    logic [WIDTH-1:0]              xmit_data;
    logic                          credit_ret;

    modport master (
        output req_valid, req_last, req_data, credit_ret,
        input  req_ready, xmit_valid, xmit_last, xmit_id, xmit_data
    );

    modport slave (
        input  req_valid, req_last, req_data, credit_ret,
        output req_ready, xmit_valid, xmit_last, xmit_id, xmit_data
    );
endinterface

// File: rtl/slr_cross_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit at or after ptr, wrapping.
module slr_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/slr_cross_arbiter.sv
// Packet-granular round-robin arbiter with credit flow control in front of a
// fixed-latency SLR crossing; beat outputs are registered.
module slr_cross_arbiter
    import slr_cross_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned CREDITS = 16,
    localparam int unsigned ID_W   = id_w(NUM_REQ),
    localparam int unsigned CNT_W  = cnt_w(CREDITS)
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 enable,
    slr_cross_arbiter_if.slave   bus,
    output logic [CNT_W-1:0]     credits_avail,
    output logic                 idle,
    output logic                 err_overflow
);
    typedef struct packed {
        logic             last;
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
    } beat_t;

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]   credit_cnt_q, credit_cnt_d;
    logic               xmit_valid_q, xmit_valid_d;
    beat_t              xmit_q, xmit_d;
    logic               err_overflow_q, err_overflow_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] ready_c;
    logic               accept_c;
    logic [ID_W-1:0]    acc_idx_c;
    logic               has_credit;

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] i);
        return (i == ID_W'(NUM_REQ - 1)) ? '0 : i + ID_W'(1);
    endfunction

    slr_rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Grant eligibility looks at the registered count only.
    assign has_credit = (credit_cnt_q != '0);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            credit_cnt_q   <= CNT_W'(CREDITS);
            xmit_valid_q   <= 1'b0;
            xmit_q         <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            credit_cnt_q   <= credit_cnt_d;
            xmit_valid_q   <= xmit_valid_d;
            xmit_q         <= xmit_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Next-state and grant decode.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        ready_c   = '0;
        accept_c  = 1'b0;
        acc_idx_c = owner_q;
        unique case (state_q)
            IDLE: begin
                if (enable && has_credit && pick_found) begin
                    ready_c   = pick_grant;
                    accept_c  = 1'b1;
                    acc_idx_c = pick_idx;
                    if (bus.req_last[pick_idx]) begin
                        rr_ptr_d = rr_next(pick_idx);
                    end else begin
                        state_d = BUSY;
                        owner_d = pick_idx;
                    end
                end
            end
            BUSY: begin
                if (bus.req_valid[owner_q] && has_credit) begin
                    ready_c[owner_q] = 1'b1;
                    accept_c         = 1'b1;
                    if (bus.req_last[owner_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = rr_next(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit accounting and the crossing-side beat register.
    always_comb begin
        credit_cnt_d   = credit_cnt_q;
        err_overflow_d = err_overflow_q;
        xmit_valid_d   = accept_c;
        xmit_d         = xmit_q;
        if (accept_c && !bus.credit_ret) begin
            credit_cnt_d = credit_cnt_q - CNT_W'(1);
        end else if (!accept_c && bus.credit_ret) begin
            if (credit_cnt_q == CNT_W'(CREDITS)) begin
                err_overflow_d = 1'b1;
            end else begin
                credit_cnt_d = credit_cnt_q + CNT_W'(1);
            end
        end
        if (accept_c) begin
            xmit_d = '{last: bus.req_last[acc_idx_c],
                       id:   acc_idx_c,
                       data: bus.req_data[acc_idx_c]};
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.xmit_valid = xmit_valid_q;
    assign bus.xmit_last  = xmit_q.last;
    assign bus.xmit_id    = xmit_q.id;
    assign bus.xmit_data  = xmit_q.data;
    assign credits_avail  = credit_cnt_q;
    assign err_overflow   = err_overflow_q;
    assign idle           = (state_q == IDLE) && (credit_cnt_q == CNT_W'(CREDITS)) && !xmit_valid_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!areset_n)
        !(accept_c && !bus.credit_ret && credit_cnt_q == '0));
endmodule

// File: tb/tb_slr_cross_arbiter.sv
// Scoreboard bench for slr_cross_arbiter: a 16-credit instance and a 4-credit instance.
module tb_slr_cross_arbiter;
    import slr_cross_arb_pkg::*;

    localparam int unsigned NR  = 4;
    localparam int unsigned W   = 16;
    localparam int unsigned CR  = 16;
    localparam int unsigned CR4 = 4;

    typedef struct packed { logic last; logic [1:0] id; logic [W-1:0] data; } exp_t;
    typedef struct packed { logic last; logic [W-1:0] data; } rbeat_t;

    logic clk = 1'b0;
    logic areset_n;
    logic enable;
    logic enable4;
    logic [cnt_w(CR)-1:0]  cred;
    logic [cnt_w(CR4)-1:0] cred4;
    logic idle, idle4, ovf, ovf4;

    slr_cross_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
    slr_cross_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus4 ();

    slr_cross_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CREDITS(CR)) dut (
        .clk(clk), .areset_n(areset_n), .enable(enable), .bus(bus),
        .credits_avail(cred), .idle(idle), .err_overflow(ovf));

    slr_cross_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CREDITS(CR4)) dut4 (
        .clk(clk), .areset_n(areset_n), .enable(enable4), .bus(bus4),
        .credits_avail(cred4), .idle(idle4), .err_overflow(ovf4));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];
    exp_t exp4_q[$];
    rbeat_t rq[NR][$];
    logic [NR-1:0] drv_acc;
    bit track = 1'b0;
    int min_cred, first_cyc, last_cyc, nbeats, nbeats4;

    function automatic logic [W-1:0] mk(input int r, input int p, input int b);
        return {4'(r), 4'(p), 8'(b)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int id, input bit last, input logic [W-1:0] d);
        exp_q.push_back('{last: last, id: 2'(id), data: d});
    endtask

    task automatic push_pkt(input int r, input int p, input int nb);
        for (int b = 0; b < nb; b++) begin
            rq[r].push_back('{last: (b == nb - 1), data: mk(r, p, b)});
            push_exp(r, (b == nb - 1), mk(r, p, b));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester model: each requester presents the head of its queue until accepted.
    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        forever begin
            @(negedge clk);
            drv_acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (drv_acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_last[i]  = rq[i][0].last;
                    bus.req_data[i]  = rq[i][0].data;
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                    bus.req_data[i]  = '0;
                end
            end
        end
    end

    // Monitor for the 16-credit instance.
    initial forever begin
        exp_t got, e;
        @(negedge clk);
        if (track) begin
            if (int'(cred) < min_cred) min_cred = int'(cred);
            if (bus.xmit_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
            end
        end
        if (areset_n && bus.xmit_valid) begin
            got = '{last: bus.xmit_last, id: bus.xmit_id, data: bus.xmit_data};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb_beat actual=%h required=%h", got, e);
                end
            end
        end
    end

    // Monitor for the 4-credit instance.
    initial forever begin
        exp_t got, e;
        @(negedge clk);
        if (areset_n && bus4.xmit_valid) begin
            nbeats4++;
            got = '{last: bus4.xmit_last, id: bus4.xmit_id, data: bus4.xmit_data};
            checks++;
            if (exp4_q.size() == 0) begin
                failures++;
                $display("FAIL sb4_unexpected actual=%h required=none", got);
            end else begin
                e = exp4_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb4_beat actual=%h required=%h", got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n        = 1'b0;
        enable          = 1'b1;
        enable4         = 1'b1;
        bus.credit_ret  = 1'b0;
        bus4.credit_ret = 1'b0;
        bus4.req_valid  = '0;
        bus4.req_last   = '0;
        bus4.req_data   = '0;
        nbeats4         = 0;
        repeat (3) @(posedge clk);
        #3 areset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_credits", 32'(cred), 16);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_xvalid", 32'(bus.xmit_valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_credits4", 32'(cred4), 4);

        // All four requesters stream single-beat packets; credits return from cycle 10
        @(posedge clk);
        for (int p = 0; p < 8; p++)
            for (int r = 0; r < NR; r++) push_pkt(r, p, 1);
        min_cred = 99; first_cyc = -1; last_cyc = -1; nbeats = 0; track = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.credit_ret = 1'b1;
        repeat (32) @(posedge clk);
        #1 bus.credit_ret = 1'b0;
        wait_drain("rr_stream");
        @(negedge clk);
        track = 1'b0;
        chk("rr_min_credits", 32'(min_cred), 6);
        chk("rr_nbeats", 32'(nbeats), 32);
        chk("rr_no_bubbles", 32'(last_cyc - first_cyc + 1), 32);
        chk("rr_credits_back", 32'(cred), 16);
        chk("rr_idle", 32'(idle), 1);

        // Move rr_ptr to 1, then a 5-beat packet from requester 1 against 0, 2, 3
        @(posedge clk);
        push_pkt(0, 8, 1);
        wait_drain("pkt_pre");
        @(posedge clk);
        push_pkt(1, 9, 5);
        push_pkt(2, 9, 1);
        push_pkt(3, 9, 1);
        push_pkt(0, 9, 1);
        wait_drain("pkt_hold");
        chk("pkt_credits", 32'(cred), 7);
        @(posedge clk);
        #1 bus.credit_ret = 1'b1;
        repeat (9) @(posedge clk);
        #1 bus.credit_ret = 1'b0;
        @(negedge clk);
        chk("pkt_credits_back", 32'(cred), 16);

        // Accept and credit return in the same cycle at count 3
        @(posedge clk);
        for (int k = 0; k < 14; k++) push_pkt(0, 10, 1);
        repeat (13) @(posedge clk);
        #1 bus.credit_ret = 1'b1;
        @(negedge clk);
        chk("same_cnt_before", 32'(cred), 3);
        chk("same_ready", 32'(bus.req_ready), 1);
        @(posedge clk);
        #1 bus.credit_ret = 1'b0;
        @(negedge clk);
        chk("same_cnt_after", 32'(cred), 3);
        wait_drain("same");
        @(posedge clk);
        #1 bus.credit_ret = 1'b1;
        repeat (13) @(posedge clk);
        #1 bus.credit_ret = 1'b0;
        @(negedge clk);
        chk("ovf_pre_credits", 32'(cred), 16);
        chk("ovf_pre_flag", 32'(ovf), 0);
        @(posedge clk);
        #1 bus.credit_ret = 1'b1;
        @(posedge clk);
        #1 bus.credit_ret = 1'b0;
        @(negedge clk);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_credits", 32'(cred), 16);
        @(negedge clk);
        chk("ovf_sticky", 32'(ovf), 1);

        // Four credits, no returns: exactly four beats, then one more per returned credit
        for (int k = 0; k < 5; k++) exp4_q.push_back('{last: 1'b1, id: 2'd0, data: 16'hA5A5});
        @(posedge clk);
        #1;
        bus4.req_valid   = 4'b0001;
        bus4.req_last    = 4'b0001;
        bus4.req_data[0] = 16'hA5A5;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("cr4_nbeats", 32'(nbeats4), 4);
        chk("cr4_ready_stall", 32'(bus4.req_ready), 0);
        chk("cr4_credits_zero", 32'(cred4), 0);
        @(posedge clk);
        #1 bus4.credit_ret = 1'b1;
        @(negedge clk);
        chk("cr4_ret_not_yet", 32'(bus4.req_ready), 0);
        @(posedge clk);
        #1 bus4.credit_ret = 1'b0;
        @(negedge clk);
        chk("cr4_ret_usable", 32'(bus4.req_ready), 1);
        chk("cr4_credits_one", 32'(cred4), 1);
        @(negedge clk);
        chk("cr4_restall", 32'(bus4.req_ready), 0);
        chk("cr4_credits_zero2", 32'(cred4), 0);
        repeat (4) @(negedge clk);
        chk("cr4_nbeats_total", 32'(nbeats4), 5);
        chk("cr4_drain", 32'(exp4_q.size()), 0);
        bus4.req_valid = '0;

        // Enable dropped mid-packet: the packet completes, nothing new starts
        @(posedge clk);
        push_pkt(2, 11, 3);
        rq[0].push_back('{last: 1'b1, data: mk(0, 11, 0)});
        @(posedge clk);
        #1 enable = 1'b0;
        wait_drain("en_pkt");
        repeat (3) @(negedge clk);
        chk("en_no_grant", 32'(bus.req_ready), 0);
        chk("en_no_xmit", 32'(bus.xmit_valid), 0);
        push_exp(0, 1'b1, mk(0, 11, 0));
        @(posedge clk);
        #1 enable = 1'b1;
        wait_drain("en_resume");
        chk("en_credits", 32'(cred), 12);

        // Reset asserted while BUSY
        @(posedge clk);
        rq[3].push_back('{last: 1'b0, data: mk(3, 12, 0)});
        rq[3].push_back('{last: 1'b0, data: mk(3, 12, 1)});
        rq[3].push_back('{last: 1'b0, data: mk(3, 12, 2)});
        rq[3].push_back('{last: 1'b1, data: mk(3, 12, 3)});
        push_exp(3, 1'b0, mk(3, 12, 0));
        push_exp(3, 1'b0, mk(3, 12, 1));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 areset_n = 1'b0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        #1;
        chk("rstb_xvalid", 32'(bus.xmit_valid), 0);
        chk("rstb_credits", 32'(cred), 16);
        chk("rstb_idle", 32'(idle), 1);
        chk("rstb_sb_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        @(posedge clk);
        #3 areset_n = 1'b1;
        @(negedge clk);
        chk("rstb_ovf_clr", 32'(ovf), 0);
        chk("rstb_ready", 32'(bus.req_ready), 0);

        // rr_ptr back at 0 after reset
        @(posedge clk);
        push_pkt(0, 13, 1);
        push_pkt(2, 13, 1);
        wait_drain("post_rst");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
